// File: rtl/imm_encoder_pkg.sv
// Shared constants for the immediate encoder and the decode-stage IMM_PICK select.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_U = 3'b010,
        FMT_B = 3'b011,
        FMT_J = 3'b100
    } fmt_e;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_t;

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational packer: scatters the immediate into the RV32 word for the chosen
// format and flags immediates that the decoder could not reproduce.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_err
);

    // An immediate fits when every bit above the field's sign bit equals it.
    logic w_fit12, w_fit13, w_fit21;
    assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        o_word = NOP_WORD;
        o_err  = 1'b1;
        case (i_fmt)
            FMT_I: begin
                o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err  = ~w_fit12;
            end
            FMT_S: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err  = ~w_fit12;
            end
            FMT_U: begin
                o_word = {i_imm[31:12], i_rd, i_opcode};
                o_err  = |i_imm[11:0];
            end
            FMT_B: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
                o_err  = ~w_fit13 | i_imm[0];
            end
            FMT_J: begin
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err  = ~w_fit21 | i_imm[0];
            end
            default: begin
                o_word = NOP_WORD;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder pipeline with running write address and
// emitted/error statistics.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_fmt,
    input  logic [6:0]       i_opcode,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_imm,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_instruction,
    output logic [31:0]      o_addr,
    output logic             o_err,
    output logic [CNT_W-1:0] o_instr_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    enc_t             w_enc;
    logic             w_s2_load, w_in_fire, w_out_fire;
    logic             r_s1_valid;
    enc_t             r_s1;
    logic             r_out_valid;
    logic [31:0]      r_instruction;
    logic             r_err;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_err_count;

    imm_pack u_pack (
        .i_fmt    (i_fmt),
        .i_opcode (i_opcode),
        .i_rd     (i_rd),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_funct3 (i_funct3),
        .i_imm    (i_imm),
        .o_word   (w_enc.word),
        .o_err    (w_enc.err)
    );

    // IN_READY depends only on pipeline state, CLEAR and OUT_READY, never IN_VALID.
    assign w_s2_load  = ~r_out_valid | i_out_ready;
    assign o_in_ready = ~i_clear & (~r_s1_valid | w_s2_load);
    assign w_in_fire  = i_in_valid & o_in_ready;
    assign w_out_fire = r_out_valid & i_out_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid    <= 1'b0;
            r_s1          <= '0;
            r_out_valid   <= 1'b0;
            r_instruction <= '0;
            r_err         <= 1'b0;
            r_addr        <= BASE_ADDR;
            r_instr_count <= '0;
            r_err_count   <= '0;
        end else if (i_clear) begin
            r_s1_valid    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_addr        <= BASE_ADDR;
            r_instr_count <= '0;
            r_err_count   <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1       <= w_enc;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_instruction <= r_s1.word;
                    r_err         <= r_s1.err;
                end
            end
            if (w_out_fire) begin
                r_addr        <= r_addr + ADDR_STEP;
                r_instr_count <= r_instr_count + CNT_ONE;
                if (r_err && !(&r_err_count))
                    r_err_count <= r_err_count + CNT_ONE;
            end
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_instruction = r_instruction;
    assign o_addr        = r_addr;
    assign o_err         = r_err;
    assign o_instr_count = r_instr_count;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized traffic
// against an arithmetic encoder/decoder model.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          CW   = 16;

    logic          clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, err;
    logic [2:0]    fmt = 3'd0, f3 = 3'd0;
    logic [6:0]    opcode = 7'd0;
    logic [4:0]    rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [31:0]   imm = 32'd0, instr, addr;
    logic [CW-1:0] icnt, ecnt;

    imm_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(rst), .i_clear(clear),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_fmt(fmt), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
        .i_funct3(f3), .i_imm(imm),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_instruction(instr), .o_addr(addr), .o_err(err),
        .o_instr_count(icnt), .o_err_count(ecnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_fail = 0;
    int          n_acc = 0, n_emit = 0;
    logic [31:0] exp_addr = BASE;
    int          exp_cnt = 0, exp_ecnt = 0;

    function automatic bit in_range(logic [31:0] v, int lo, int hi);
        int s;
        s = $signed(v);
        return (s >= lo) && (s <= hi);
    endfunction

    function automatic exp_t model(logic [2:0] f, logic [6:0] op, logic [4:0] d,
                                   logic [4:0] s1, logic [4:0] s2, logic [2:0] fn,
                                   logic [31:0] v);
        exp_t e;
        e.fmt = f; e.imm = v;
        case (f)
            3'd0: begin e.word = {v[11:0], s1, fn, d, op};                 e.err = !in_range(v, -2048, 2047); end
            3'd1: begin e.word = {v[11:5], s2, s1, fn, v[4:0], op};        e.err = !in_range(v, -2048, 2047); end
            3'd2: begin e.word = {v[31:12], d, op};                        e.err = (v % 4096) != 0; end
            3'd3: begin e.word = {v[12], v[10:5], s2, s1, fn, v[4:1], v[11], op};
                        e.err = !in_range(v, -4096, 4095) || (v % 2 != 0); end
            3'd4: begin e.word = {v[20], v[10:1], v[11], v[19:12], d, op};
                        e.err = !in_range(v, -1048576, 1048575) || (v % 2 != 0); end
            default: begin e.word = 32'h0000_0013; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Decode-stage extractor, expressed as signed arithmetic on the word.
    function automatic int extract(logic [2:0] f, logic [31:0] w);
        int sw;
        sw = $signed(w);
        case (f)
            3'd0: return sw >>> 20;
            3'd1: return (sw >>> 25) * 32 + int'(w[11:7]);
            3'd2: return sw - int'(w[11:0]);
            3'd3: return (sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            3'd4: return (sw >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] rand_imm(logic [2:0] f);
        logic [31:0] r;
        r = $urandom;
        case (f)
            3'd0, 3'd1: return $urandom_range(0, 4095) - 2048;
            3'd2:       return r & 32'hFFFF_F000;
            3'd3:       return ($urandom_range(0, 4095) - 2048) * 2;
            default:    return ($urandom_range(0, 1048575) - 524288) * 2;
        endcase
    endfunction

    task automatic set_req(logic [2:0] f, logic [6:0] op, logic [4:0] d, logic [4:0] s1,
                           logic [4:0] s2, logic [2:0] fn, logic [31:0] v);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn; imm = v;
    endtask

    task automatic set_rand_req();
        logic [2:0] f;
        f = 3'($urandom_range(0, 4));
        set_req(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                ($urandom_range(0, 9) == 0) ? $urandom : rand_imm(f));
    endtask

    // Advance one cycle: record both handshakes into the model, then land on the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (clear) begin
            q.delete(); exp_addr = BASE; exp_cnt = 0; exp_ecnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    if (e.err && exp_ecnt < (1 << CW) - 1) exp_ecnt++;
                end
                exp_addr = exp_addr + 32'd4; exp_cnt++; n_emit++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(fmt, opcode, rd, rs1, rs2, f3, imm)); n_acc++;
            end
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic wait_out(output bit ok);
        repeat (8) if (!out_valid) tick();
        ok = out_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || instr !== 32'd0 || addr !== BASE || err !== 1'b0 ||
            icnt !== '0 || ecnt !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%b instr=%h addr=%h err=%b cnt=%0d ecnt=%0d, required 0/0/%h/0/0/0",
                     out_valid, instr, addr, err, icnt, ecnt, BASE);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_itype();
        set_req(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL itype_latency1: valid=%b required 0", out_valid); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || instr !== 32'hFFF1_0093 || err !== 1'b0 || addr !== BASE) begin
            n_fail++;
            $display("FAIL itype: valid=%b instr=%h err=%b addr=%h, required 1/fff10093/0/%h",
                     out_valid, instr, err, addr, BASE);
        end
        tick();
        n_cmp++;
        if (icnt !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL itype_count: cnt=%0d valid=%b required 1/0", icnt, out_valid);
        end
    endtask

    task automatic test_btype();
        bit ok;
        set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, -32'sd4);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        wait_out(ok);
        n_cmp++;
        if (!ok || instr !== 32'hFE20_9EE3 || err !== 1'b0 || addr !== BASE + 32'd4) begin
            n_fail++;
            $display("FAIL btype: ok=%b instr=%h err=%b addr=%h, required 1/fe209ee3/0/%h",
                     ok, instr, err, addr, BASE + 32'd4);
        end
        tick();
        imm = 32'd3;
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        wait_out(ok);
        n_cmp++;
        if (!ok || err !== 1'b1 || instr !== q[0].word) begin
            n_fail++; $display("FAIL btype_misaligned: ok=%b err=%b instr=%h, required 1/1/%h", ok, err, instr, q[0].word);
        end
        tick();
        n_cmp++;
        if (ecnt !== 16'd1) begin n_fail++; $display("FAIL btype_errcount: got %0d required 1", ecnt); end
    endtask

    task automatic test_invalid();
        bit ok;
        set_req(3'b111, 7'h33, 5'd3, 5'd4, 5'd5, 3'd2, 32'd0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        wait_out(ok);
        n_cmp++;
        if (!ok || instr !== 32'h0000_0013 || err !== 1'b1) begin
            n_fail++; $display("FAIL bad_fmt: ok=%b instr=%h err=%b, required 1/00000013/1", ok, instr, err);
        end
        tick();
        set_req(3'd2, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'h0000_1001);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        wait_out(ok);
        n_cmp++;
        if (!ok || instr !== 32'h0000_13B7 || err !== 1'b1) begin
            n_fail++; $display("FAIL utype_low_bits: ok=%b instr=%h err=%b, required 1/000013b7/1", ok, instr, err);
        end
        tick();
        n_cmp++;
        if (ecnt !== 16'd3 || addr !== exp_addr) begin
            n_fail++; $display("FAIL invalid_stats: ecnt=%0d addr=%h, required 3/%h", ecnt, addr, exp_addr);
        end
    endtask

    task automatic test_random();
        int rt_cmp;
        rt_cmp = 0;
        for (int c = 0; c < 3000 + 20; c++) begin
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious: instr=%h with nothing in flight", instr);
                end else if (instr !== q[0].word || err !== q[0].err || addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL rand_word: instr=%h err=%b addr=%h, required %h/%b/%h",
                             instr, err, addr, q[0].word, q[0].err, exp_addr);
                end else if (!q[0].err) begin
                    rt_cmp++; n_cmp++;
                    if (extract(q[0].fmt, instr) != int'(q[0].imm)) begin
                        n_fail++;
                        $display("FAIL round_trip: fmt=%0d extracted=%h required %h",
                                 q[0].fmt, extract(q[0].fmt, instr), q[0].imm);
                    end
                end
            end
            if (c < 3000) begin
                set_rand_req();
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            tick();
        end
        n_cmp++;
        if (q.size() != 0 || icnt !== CW'(exp_cnt) || ecnt !== CW'(exp_ecnt) || rt_cmp < 500) begin
            n_fail++;
            $display("FAIL rand_totals: left=%0d cnt=%0d ecnt=%0d roundtrips=%0d, required 0/%0d/%0d/>=500",
                     q.size(), icnt, ecnt, rt_cmp, exp_cnt, exp_ecnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held_instr, held_addr;
        n_acc = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_req(3'd0, 7'h13, 5'(c + 1), 5'd0, 5'd0, 3'd0, 32'(c * 16));
            tick();
        end
        held_instr = instr; held_addr = addr;
        #1;
        n_cmp++;
        if (n_acc != 2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 2/0", n_acc, in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || instr !== held_instr || addr !== held_addr || instr !== q[0].word) begin
            n_fail++; $display("FAIL bp_hold: instr=%h addr=%h, required %h/%h", instr, addr, q[0].word, held_addr);
        end
        in_valid = 1'b0; out_ready = 1'b1; n_emit = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0 || instr !== q[0].word || addr !== exp_addr) begin
                    n_fail++; $display("FAIL bp_order: instr=%h addr=%h, required %h", instr, addr, exp_addr);
                end
            end
            tick();
        end
        n_cmp++;
        if (n_emit != 2 || q.size() != 0) begin
            n_fail++; $display("FAIL bp_drain: emitted=%0d left=%0d, required 2/0", n_emit, q.size());
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b0; in_valid = 1'b1;
        set_req(3'd1, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'd8);
        tick(); tick(); tick();
        clear = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL clear_in_ready: in_ready=%b valid=%b, required 0/1", in_ready, out_valid);
        end
        tick();
        clear = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== BASE || icnt !== '0 || ecnt !== '0) begin
            n_fail++;
            $display("FAIL clear: valid=%b addr=%h cnt=%0d ecnt=%0d, required 0/%h/0/0", out_valid, addr, icnt, ecnt, BASE);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_flush: valid=%b required 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        set_req(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || instr !== 32'd0 || addr !== BASE || err !== 1'b0 || icnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b instr=%h addr=%h err=%b cnt=%0d, required 0/0/%h/0/0",
                     out_valid, instr, addr, err, icnt, BASE);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete(); exp_addr = BASE; exp_cnt = 0; exp_ecnt = 0;
        tick(); tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_loss: valid=%b required 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_btype();
        test_invalid();
        test_random();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extractor: packs register fields, funct fields and a 32-bit signed immediate into an RV32 instruction word for the selected format (I/S/U/B/J).
- Used by the boot/instruction-memory loader and the self-test program generator.
- Two-stage valid/ready pipeline with immediate range and alignment checking, a running instruction-memory write address, and error statistics.

Parameters:
- BASE_ADDR, 32'h0000_0000, address reported with the first emitted instruction after reset or CLEAR.
- CNT_W, 16, width of INSTR_COUNT and ERR_COUNT.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CLEAR  in  1  synchronous flush: empties pipeline, reloads address, zeroes counters.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  request accepted when IN_VALID && IN_READY.
- FMT  in  3  000 I, 001 S, 010 U, 011 B, 100 J; others invalid. Same coding as the decode-stage IMM_PICK select.
- OPCODE  in  7  instruction[6:0].
- RD  in  5  destination register; used by I, U and J.
- RS1  in  5  source 1; used by I, S and B.
- RS2  in  5  source 2; used by S and B.
- FUNCT3  in  3  used by I, S and B.
- IMM  in  32  signed immediate, as the decoder would reproduce it.
- OUT_VALID  out  1  encoded word valid.
- OUT_READY  in  1  consumer ready.
- INSTRUCTION  out  32  encoded word.
- ADDR  out  32  memory address for INSTRUCTION.
- ERR  out  1  word flagged as range, alignment or format error.
- INSTR_COUNT  out  CNT_W  words emitted, wraps.
- ERR_COUNT  out  CNT_W  erroneous words emitted, saturates at all-ones.

Behaviour:
- Reset (async) values: OUT_VALID=0, INSTRUCTION=0, ADDR=BASE_ADDR, ERR=0, both counters 0, internal stage valids 0.
- Encoding (bit positions exactly inverse to the decoder):
  - I: {IMM[11:0], RS1, FUNCT3, RD, OPCODE}.
  - S: {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE}.
  - U: {IMM[31:12], RD, OPCODE}.
  - B: {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE}.
  - J: {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE}.
- Error checks:
  - I/S: IMM[31:11] not all equal.
  - U: IMM[11:0] != 0.
  - B: IMM[31:12] not all equal, or IMM[0]=1.
  - J: IMM[31:20] not all equal, or IMM[0]=1.
- On a range or alignment error the word is still emitted using truncated bits, with ERR=1.
- Invalid FMT: INSTRUCTION=32'h0000_0013 (NOP), ERR=1.
- Stage 1 registers the encoded word and error bit at input handshake. Stage 2 is the output register.
- Latency: 2 cycles from input handshake to OUT_VALID when unstalled. Throughput 1 word/cycle.
- Handshake rules:
  - Stage 2 loads when (!OUT_VALID || OUT_READY).
  - Stage 1 advances when stage 2 loads.
  - IN_READY = !CLEAR && (!s1_valid || stage-2 load condition). IN_READY is combinational from OUT_READY, and no combinational path exists from IN_VALID to IN_READY.
  - INSTRUCTION, ADDR and ERR hold stable while OUT_VALID && !OUT_READY.
- On output handshake (OUT_VALID && OUT_READY):
  - ADDR += 4 for the next word, wrapping modulo 2^32.
  - INSTR_COUNT += 1, wrapping.
  - ERR_COUNT += ERR, saturating.
- CLEAR (synchronous) takes priority over all other events in that cycle:
  - Both stage valids cleared and any in-flight word discarded.
  - ADDR=BASE_ADDR, counters zeroed.
  - No input is accepted during the CLEAR cycle.
  - A handshake in the CLEAR cycle does not update ADDR or the counters.
- RESET asserted mid-stream: all words in flight are lost immediately; no partial output.

Decomposition:
- Shared package holds:
  - format codes FMT_I=3'b000, FMT_S=3'b001, FMT_U=3'b010, FMT_B=3'b011, FMT_J=3'b100;
  - NOP_WORD=32'h0000_0013.
  - The decoder's select input must use the same constants.
- One natural combinational sub-module, imm_pack: inputs FMT, fields and IMM; outputs the packed word and an error bit. imm_encoder contains the pipeline, address and counters.

Test Plan:
- I-type, IMM=-1, RS1=2, FUNCT3=0, RD=1, OPCODE=7'h13, OUT_READY=1 -> INSTRUCTION=32'hFFF1_0093, ERR=0, ADDR=BASE_ADDR, OUT_VALID 2 cycles after handshake.
- B-type, IMM=-4, RS1=1, RS2=2, FUNCT3=1, OPCODE=7'h63 -> INSTRUCTION=32'hFE20_9EE3. Same request with IMM=3 -> ERR=1, ERR_COUNT=1.
- Round trip: 10k random in-range requests per format, fed back through the decode-stage extractor -> extracted immediate equals IMM; ADDR advances by 4 per word; INSTR_COUNT equals the number of words emitted.
- Backpressure: OUT_READY=0 for 5 cycles with continuous IN_VALID -> exactly 2 words accepted, IN_READY=0 afterwards, output held stable; on release, words emerge in order with no loss or duplication.
- FMT=3'b111 -> INSTRUCTION=32'h0000_0013, ERR=1. U-type with IMM=32'h0000_1001 -> ERR=1.
- CLEAR with 2 words in flight and IN_VALID=1 -> IN_READY=0, next cycle OUT_VALID=0, ADDR=BASE_ADDR, counters 0. Async RESET asserted mid-cycle -> outputs reset immediately, without waiting for CLK.
